// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential shift-add-3 (double-dabble) binary-to-BCD converter.
//
// Converts one input bit per clock. A WIDTH-bit unsigned value takes WIDTH
// shift cycles plus one DONE cycle. Digits that do not fit in DIGITS
// positions are dropped and flagged on ovf.
//
// Parameters
//   WIDTH      bit width of the unsigned binary input
//   DIGITS     number of BCD digits produced
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous, active-high reset
//   start      convert request, sampled only in IDLE
//   bin        unsigned value, captured on an accepted start
//   busy       high while the shift phase runs
//   finish     one-cycle pulse, bcd/bcd_valid/ovf hold the new result
//   bcd        packed BCD, digit 0 (units) in [3:0]
//   bcd_valid  per-digit display enable, bit 0 = units
//   ovf        result >= 10**DIGITS (upper digits truncated)
//
// Build option
//   BIN2BCD_BLANK_EN  leading-zero blanking on bcd_valid; when undefined
//                     bcd_valid is tied to all ones.

module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  finish,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     bcd_valid,
   output logic                  ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t               state;
   state_t               state_nx;

   logic [WIDTH-1:0]     shreg;
   logic [4*DIGITS-1:0]  dig;
   logic [4*DIGITS-1:0]  dig_adj;
   logic [4*DIGITS-1:0]  dig_nx;
   logic                 sticky;
   logic                 sticky_nx;
   logic [CW-1:0]        cnt;
   logic                 last;

   assign last = (cnt == CW'(WIDTH - 1));

   // Add-3 on every digit >= 5 (4-bit wrap), then shift {digits, shreg} left.
   // The bit falling out of the top digit is a lost decimal carry.
   always_comb begin
      dig_adj = dig;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (dig[4*k +: 4] >= 4'd5) begin
            dig_adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
         end
      end
      dig_nx    = {dig_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
      sticky_nx = sticky | dig_adj[4*DIGITS-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // The result registers load on the edge that enters DONE, straight from the
   // final shift value, so they are already valid while finish is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg  <= '0;
         dig    <= '0;
         sticky <= 1'b0;
         cnt    <= '0;
         bcd    <= '0;
         ovf    <= 1'b0;
         finish <= 1'b0;
      end else begin
         finish <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg  <= bin;
                  dig    <= '0;
                  sticky <= 1'b0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               shreg  <= shreg << 1;
               dig    <= dig_nx;
               sticky <= sticky_nx;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  bcd    <= dig_nx;
                  ovf    <= sticky_nx;
                  finish <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] valid_nx;
   logic              seen;

   // Scan from the most significant digit down: a digit is shown once any
   // digit at or above it is nonzero. Units always shown so 0 reads "0".
   always_comb begin
      valid_nx = '0;
      seen     = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         seen                    = seen | (dig_nx[4*(DIGITS-1-i) +: 4] != 4'd0);
         valid_nx[DIGITS-1-i]    = seen;
      end
      valid_nx[0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_valid <= DIGITS'(1);
      end else if (state == SHIFT && last) begin
         bcd_valid <= valid_nx;
      end
   end
`else
   assign bcd_valid = '1;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- bench for bin2bcd_seq.
// Two instances share clk/rst/start/bin: a 3-digit converter and a 2-digit
// converter (exercises truncation/overflow). Both have WIDTH=8 so they finish
// on the same cycle.

module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  bin;

   logic        busy3, finish3, ovf3;
   logic [11:0] bcd3;
   logic [2:0]  valid3;

   logic        busy2, finish2, ovf2;
   logic [7:0]  bcd2;
   logic [1:0]  valid2;

   int errors = 0;
   int checks = 0;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bin       (bin),
      .busy      (busy3),
      .finish    (finish3),
      .bcd       (bcd3),
      .bcd_valid (valid3),
      .ovf       (ovf3)
   );

   bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bin       (bin),
      .busy      (busy2),
      .finish    (finish2),
      .bcd       (bcd2),
      .bcd_valid (valid2),
      .ovf       (ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Pulse start for one edge, then wait (bounded) for finish.
   // lat counts cycles after the accept edge; -1 if finish never came.
   task automatic run_conv(input logic [7:0] v, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy3) bcnt++;
         if (finish3) begin
            lat = c;
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] bcd3;
      logic [2:0]  v3;
      logic [7:0]  bcd2;
      logic        ovf2;
      logic [1:0]  v2;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [2:0] exp_v3(input logic [2:0] blank);
`ifdef BIN2BCD_BLANK_EN
      return blank;
`else
      return (blank == 3'b000) ? 3'b000 : 3'b111;
`endif
   endfunction

   function automatic logic [1:0] exp_v2(input logic [1:0] blank);
`ifdef BIN2BCD_BLANK_EN
      return blank;
`else
      return (blank == 2'b00) ? 2'b00 : 2'b11;
`endif
   endfunction

   initial begin
      int lat, bcnt, nfin;
      logic [11:0] held;

      vecs[0]  = '{8'd255, 12'h255, 3'b111, 8'h55, 1'b1, 2'b11};
      vecs[1]  = '{8'd105, 12'h105, 3'b111, 8'h05, 1'b1, 2'b01};
      vecs[2]  = '{8'd0,   12'h000, 3'b001, 8'h00, 1'b0, 2'b01};
      vecs[3]  = '{8'd7,   12'h007, 3'b001, 8'h07, 1'b0, 2'b01};
      vecs[4]  = '{8'd40,  12'h040, 3'b011, 8'h40, 1'b0, 2'b11};
      vecs[5]  = '{8'd42,  12'h042, 3'b011, 8'h42, 1'b0, 2'b11};
      vecs[6]  = '{8'd99,  12'h099, 3'b011, 8'h99, 1'b0, 2'b11};
      vecs[7]  = '{8'd200, 12'h200, 3'b111, 8'h00, 1'b1, 2'b01};
      vecs[8]  = '{8'd128, 12'h128, 3'b111, 8'h28, 1'b1, 2'b11};
      vecs[9]  = '{8'd100, 12'h100, 3'b111, 8'h00, 1'b1, 2'b01};
      vecs[10] = '{8'd10,  12'h010, 3'b011, 8'h10, 1'b0, 2'b11};
      vecs[11] = '{8'd1,   12'h001, 3'b001, 8'h01, 1'b0, 2'b01};

      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("reset busy",   32'(busy3),   32'd0);
      chk("reset finish", 32'(finish3), 32'd0);
      chk("reset bcd",    32'(bcd3),    32'd0);
      chk("reset ovf",    32'(ovf3),    32'd0);
      chk("reset valid",  32'(valid3),  32'(exp_v3(3'b001)));
      chk("reset valid2", 32'(valid2),  32'(exp_v2(2'b01)));

      // Table-driven conversions
      foreach (vecs[i]) begin
         run_conv(vecs[i].bin, lat, bcnt);
         chk($sformatf("latency[%0d]", vecs[i].bin), 32'(lat), 32'd9);
         chk($sformatf("busy cycles[%0d]", vecs[i].bin), 32'(bcnt), 32'd8);
         chk($sformatf("bcd3[%0d]", vecs[i].bin), 32'(bcd3), 32'(vecs[i].bcd3));
         chk($sformatf("ovf3[%0d]", vecs[i].bin), 32'(ovf3), 32'd0);
         chk($sformatf("valid3[%0d]", vecs[i].bin), 32'(valid3), 32'(exp_v3(vecs[i].v3)));
         chk($sformatf("finish2[%0d]", vecs[i].bin), 32'(finish2), 32'd1);
         chk($sformatf("bcd2[%0d]", vecs[i].bin), 32'(bcd2), 32'(vecs[i].bcd2));
         chk($sformatf("ovf2[%0d]", vecs[i].bin), 32'(ovf2), 32'(vecs[i].ovf2));
         chk($sformatf("valid2[%0d]", vecs[i].bin), 32'(valid2), 32'(exp_v2(vecs[i].v2)));
         @(negedge clk);
         chk($sformatf("finish pulse[%0d]", vecs[i].bin), 32'(finish3), 32'd0);
         chk($sformatf("bcd hold[%0d]", vecs[i].bin), 32'(bcd3), 32'(vecs[i].bcd3));
      end

      // Result holds while idle
      held = bcd3;
      repeat (5) @(negedge clk);
      chk("idle hold", 32'(bcd3), 32'(held));
      chk("idle busy", 32'(busy3), 32'd0);

      // Start held 20 cycles, bin changes mid-run: two conversions, the
      // second accepted only after IDLE is re-entered.
      nfin = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (finish3) begin
            nfin++;
            if (i == 9) begin
               chk("held start first bcd", 32'(bcd3), 32'h123);
            end else if (i == 19) begin
               chk("held start second bcd", 32'(bcd3), 32'h077);
               chk("held start second ovf2", 32'(ovf2), 32'd0);
               chk("held start second bcd2", 32'(bcd2), 32'h77);
            end else begin
               chk($sformatf("held start finish at %0d", i), 32'(finish3), 32'd0);
            end
         end
         start = (i < 20);
         bin   = (i < 4) ? 8'd123 : 8'd77;
      end
      chk("held start finish count", 32'(nfin), 32'd2);
      start = 1'b0;

      // Start pulses during busy are ignored
      @(negedge clk);
      bin   = 8'd31;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bin   = 8'd250;
      nfin  = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3 || i == 9) start = 1'b1;
         else start = 1'b0;
         @(negedge clk);
         if (finish3) begin
            nfin++;
            chk("busy start ignored bcd", 32'(bcd3), 32'h031);
         end
      end
      start = 1'b0;
      chk("busy start finish count", 32'(nfin), 32'd1);

      // Reset mid-conversion
      @(negedge clk);
      bin   = 8'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      nfin = 0;
      chk("abort busy",  32'(busy3), 32'd0);
      chk("abort bcd",   32'(bcd3),  32'd0);
      chk("abort ovf",   32'(ovf3),  32'd0);
      chk("abort valid", 32'(valid3), 32'(exp_v3(3'b001)));
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (finish3) nfin++;
      end
      chk("abort no finish", 32'(nfin), 32'd0);
      run_conv(8'd42, lat, bcnt);
      chk("after abort latency", 32'(lat), 32'd9);
      chk("after abort bcd", 32'(bcd3), 32'h042);
      chk("after abort ovf", 32'(ovf3), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
